led_indicator_ctrl: RTL
=======================

# led_indicator_ctrl

Parametrised, registered LED indicator controller that displays a classification result on a bank of board LEDs. It accepts a result code through a valid/ready handshake, holds the decoded pattern for a programmable time, optionally blinks it, and flags out-of-range codes with a blinking all-on error pattern. After reset it runs a lamp test. It sits at the output of the classifier datapath and drives the LED pins directly.

## Interface
- `CODE_W`, default 3: result code width.
- `NUM_LEDS`, default 3: LED count. Must satisfy `NUM_LEDS >= $clog2(NUM_CLASSES+1)`.
- `NUM_CLASSES`, default 5: number of valid codes, `0..NUM_CLASSES-1`.
- `BLINK_DIV`, default 25_000_000: clock cycles per blink half-period. Must be at least 1.
- `HOLD_CYCLES`, default 100_000_000: display duration in cycles. A value of 0 means hold until the next code.
- `LAMP_CYCLES`, default 50_000_000: lamp-test duration after reset. Must be at least 1.
- `clk`, input, 1: system clock, one clock domain.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `code_valid`, input, 1: the code is presented.
- `code`, input, `CODE_W`: result code.
- `blink_en`, input, 1: when 1, valid-code patterns blink; when 0, they are steady. Sampled every cycle.
- `code_ready`, output, 1: the controller can accept a code.
- `leds`, output, `NUM_LEDS`: LED drive, active-high, registered.
- `disp_active`, output, 1: the state is SHOW or ERROR.

## Operation
- States: LAMP, IDLE, SHOW, ERROR.
- Reset (asynchronous assert) values:
  - state = LAMP
  - `leds` = all ones
  - `code_ready` = 0
  - `disp_active` = 0
  - counters cleared, lamp counter loaded with `LAMP_CYCLES-1`
- LAMP:
  - `leds` are all ones and `code_ready` is 0.
  - Codes are not accepted; `code_valid` is ignored.
  - When the lamp counter reaches 0, go to IDLE.
- IDLE:
  - `leds` = 0 and `code_ready` = 1.
- Accept means `code_valid && code_ready` at a rising edge. It is legal in IDLE, SHOW and ERROR.
  - If `code < NUM_CLASSES`: go to SHOW and latch pattern = `(code+1)` truncated to `NUM_LEDS` bits.
    - Codes 0..4 map to 001, 010, 011, 100, 101 for `{led2,led1,led0}`.
  - If `code >= NUM_CLASSES`: go to ERROR.
  - Every accept reloads the hold counter with `HOLD_CYCLES-1`, clears the blink prescaler and sets blink phase = ON.
- SHOW:
  - `leds` = pattern when `blink_en`=0 or phase=ON; otherwise `leds` = 0.
- ERROR:
  - `leds` = all ones when phase=ON, 0 when phase=OFF. Blinking here is unconditional; `blink_en` is ignored.
- Hold expiry (`HOLD_CYCLES>0`):
  - The hold counter decrements each cycle in SHOW or ERROR.
  - When it is 0 and there is no accept that cycle, go to IDLE.
  - If an accept coincides with expiry, the accept wins.
- Blink phase: the prescaler counts 0..`BLINK_DIV-1` in SHOW and ERROR; at the terminal count the phase toggles.
- `disp_active` = 1 exactly when the state is SHOW or ERROR.
- Reset mid-display: immediate return to the reset values and LAMP, with any latched code discarded.

## Timing
- Acceptance to `leds` change has 1-cycle latency: accept at edge T gives the new `leds` value after edge T.
- Pattern visible for exactly `HOLD_CYCLES` cycles; `leds` = 0 after the edge that ends the final cycle.
- Lamp test lasts exactly `LAMP_CYCLES` cycles after `rst_n` deasserts. `code_ready` rises with the IDLE entry edge.
- Blink: phase ON for the first `BLINK_DIV` cycles after accept, then OFF for `BLINK_DIV` cycles, repeating.
- `blink_en` change takes effect on `leds` at the next edge; the phase counter is unaffected.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Shared package/include `led_ind_pkg` holds:
  - state encoding: LAMP=2'd0, IDLE=2'd1, SHOW=2'd2, ERROR=2'd3
  - the counter-width function `$clog2(max(x,2))`
- Sub-module `led_blink_timer` holds the prescaler and phase flop.
  - Ports: `clk`, `rst_n`, `restart`, `run`, `phase`.
  - Parameter: `BLINK_DIV`.
- The top level holds the FSM, hold counter, lamp counter, pattern register and output registers.

## Test plan
Bench parameters: `BLINK_DIV`=4, `HOLD_CYCLES`=20, `LAMP_CYCLES`=8.

- **Lamp test:** release reset → `leds`=111 and `code_ready`=0 for 8 cycles, then `leds`=000 and `code_ready`=1. A `code_valid` pulse during LAMP is ignored.
- **Steady display:** accept `code`=2 with `blink_en`=0 → `leds`=011 on the next cycle for 20 cycles, `disp_active`=1, then `leds`=000 and `disp_active`=0.
- **Blink:** accept `code`=4 with `blink_en`=1 → `leds` alternate 101 ×4 cycles, 000 ×4 cycles, and so on, with blanking after 20 cycles.
- **Error:** accept `code`=6 → `leds` alternate 111/000 with a 4-cycle half-period for 20 cycles, then IDLE.
- **Replace at expiry:** accept `code`=0 exactly on the expiry cycle of `code`=1 → `leds`=001 the next cycle, with the hold restarted at a full 20 cycles.
- **Reset mid-operation:** assert `rst_n`=0 during SHOW → `leds`=111 and `code_ready`=0 immediately and asynchronously; after release the lamp test repeats. Repeat with `HOLD_CYCLES`=0 and check that the pattern holds indefinitely.

Source files
------------

// File: rtl/led_ind_pkg.sv
// led_ind_pkg: shared FSM state encoding and counter-width helper for the LED indicator controller.
package led_ind_pkg;
  typedef enum logic [1:0] {
    LAMP  = 2'd0,
    IDLE  = 2'd1,
    SHOW  = 2'd2,
    ERROR = 2'd3
  } state_t;
  function automatic int cnt_w(input int x);
    return $clog2(x < 2 ? 2 : x);
  endfunction
endpackage

// File: rtl/led_blink_timer.sv
// led_blink_timer: blink prescaler and phase flop for the LED indicator controller.
//   clk, rst_n : clock and asynchronous active-low reset
//   restart    : an accept this cycle, blink sequence starts over with phase ON
//   run        : the controller is displaying in the next cycle
//   phase      : 1 = ON, valid for the cycle that follows the next clock edge
module led_blink_timer
  import led_ind_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic phase
);
  localparam int W = cnt_w(BLINK_DIV);
  localparam logic [W-1:0] LAST = W'(BLINK_DIV - 1);
  // The state is kept one cycle ahead so the registered LED drive can use it
  // directly; after a restart it already holds the second post-accept cycle.
  localparam logic [W-1:0] CNT_AHEAD = W'(BLINK_DIV == 1 ? 0 : 1);
  localparam logic PH_AHEAD = BLINK_DIV != 1;
  logic [W-1:0] r_cnt;
  logic r_phase;
  logic w_wrap;
  assign w_wrap = r_cnt == LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (restart) begin
      r_cnt   <= CNT_AHEAD;
      r_phase <= PH_AHEAD;
    end else if (run) begin
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      r_phase <= w_wrap ? ~r_phase : r_phase;
    end
  end
  assign phase = r_phase;
endmodule

// File: rtl/led_indicator_ctrl.sv
// led_indicator_ctrl: registered LED indicator showing a classification code with hold, blink and lamp test.
//   clk, rst_n  : clock and asynchronous active-low reset
//   code_valid  : code presented (valid/ready handshake with code_ready)
//   code        : result code; codes >= NUM_CLASSES show the blinking error pattern
//   blink_en    : blink valid-code patterns when 1
//   code_ready  : controller accepts a code (every state except LAMP)
//   leds        : registered active-high LED drive
//   disp_active : a pattern (SHOW) or the error pattern (ERROR) is displayed
module led_indicator_ctrl
  import led_ind_pkg::*;
#(
  parameter int CODE_W      = 3,
  parameter int NUM_LEDS    = 3,
  parameter int NUM_CLASSES = 5,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int LAMP_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                code_valid,
  input  logic [CODE_W-1:0]   code,
  input  logic                blink_en,
  output logic                code_ready,
  output logic [NUM_LEDS-1:0] leds,
  output logic                disp_active
);
  localparam int LW = cnt_w(LAMP_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam logic [LW-1:0] LAMP_LOAD = LW'(LAMP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  state_t r_state, w_state_nx;
  logic [LW-1:0] r_lamp;
  logic [HW-1:0] r_hold;
  logic [NUM_LEDS-1:0] r_pat, r_leds, w_code_pat, w_pat_nx, w_leds_nx;
  logic r_ready, r_disp;
  logic w_accept, w_valid_code, w_expire, w_disp_nx, w_phase, w_phase_on;
  assign w_accept     = code_valid && r_ready;
  assign w_valid_code = 32'(code) < NUM_CLASSES;
  assign w_code_pat   = NUM_LEDS'(code) + NUM_LEDS'(1);
  // HOLD_CYCLES == 0 never expires: the display stays until the next code
  assign w_expire     = HOLD_CYCLES > 0 && r_hold == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LAMP;
    else        r_state <= w_state_nx;
  end
  always_comb begin
    w_state_nx = r_state;
    if (r_state == LAMP)
      w_state_nx = r_lamp == '0 ? IDLE : LAMP;
    else if (w_accept)
      w_state_nx = w_valid_code ? SHOW : ERROR;
    else if (r_state != IDLE && w_expire)
      w_state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lamp <= LAMP_LOAD;
      r_hold <= '0;
      r_pat  <= '0;
    end else begin
      if (r_state == LAMP && r_lamp != '0) r_lamp <= r_lamp - 1'b1;
      if (w_accept) r_hold <= HOLD_LOAD;
      else if ((r_state == SHOW || r_state == ERROR) && r_hold != '0) r_hold <= r_hold - 1'b1;
      if (w_accept && w_valid_code) r_pat <= w_code_pat;
    end
  end
  led_blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_accept),
    .run     (w_disp_nx),
    .phase   (w_phase)
  );
  // Output registers are loaded from next-state values so an accept at an
  // edge shows its pattern in the very next cycle.
  always_comb begin
    w_disp_nx  = w_state_nx == SHOW || w_state_nx == ERROR;
    w_pat_nx   = (w_accept && w_valid_code) ? w_code_pat : r_pat;
    w_phase_on = w_accept || w_phase;
    w_leds_nx  = w_state_nx == LAMP ? '1 :
                 w_state_nx == SHOW ? ((!blink_en || w_phase_on) ? w_pat_nx : '0) :
                 (w_state_nx == ERROR && w_phase_on) ? '1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_leds  <= '1;
      r_ready <= 1'b0;
      r_disp  <= 1'b0;
    end else begin
      r_leds  <= w_leds_nx;
      r_ready <= w_state_nx != LAMP;
      r_disp  <= w_disp_nx;
    end
  end
  assign leds        = r_leds;
  assign code_ready  = r_ready;
  assign disp_active = r_disp;
endmodule
